mmio_event_unit: RTL and testbench
==================================

Name: mmio_event_unit

Overview:
- Produces the status and counter values that the MMIO load-data select path returns: a free-running cycle counter, a retired-instruction counter and a button-event FIFO.
- Sits beside the memory stage. It snoops the stage's address and load/store strobes to detect counter-reset stores and button-FIFO pops.
- Outputs go straight to the load-data select; no read muxing is done here.

Parameters:
- FIFO_DEPTH, 8, number of button-event entries; power of two, at least 2.
- PTR_W, 3, pointer width; equals log2(FIFO_DEPTH).

Ports:
- clk  input  1  single core clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk edge.
- mem_addr  input  32  memory-stage effective address.
- mem_re  input  1  memory-stage load valid this cycle.
- mem_we  input  1  memory-stage store valid this cycle.
- stall  input  1  pipeline stall; a stalled access has no side effect.
- inst_valid  input  1  one instruction retires this cycle.
- btn_pulse  input  3  debounced one-cycle button edge pulses, one bit per button.
- counter_cycle  output  32  cycles since last reset or clear.
- counter_inst  output  32  retired instructions since last reset or clear.
- buttons_empty  output  1  FIFO holds no entry.
- buttons  output  3  FIFO head entry; 3'b000 when empty.
- buttons_full  output  1  FIFO holds FIFO_DEPTH entries.

Behaviour:
- Reset (rst_n low at an edge): counters become 0, FIFO pointers and count become 0. After that edge buttons_empty=1, buttons_full=0, buttons=0. Reset overrides every other event in the same cycle, including mid-pop and mid-clear.
- Address decode (full 32-bit compare):
  - CLR_ADDR = 0x8000_0018.
  - POP_ADDR = 0x8000_0024.
  - clear = mem_we & ~stall & (mem_addr == CLR_ADDR).
  - pop_req = mem_re & ~stall & (mem_addr == POP_ADDR).
- Cycle counter:
  - Each edge: clear ? 0 : counter_cycle + 1.
  - Wraps 0xFFFF_FFFF -> 0. Increments during stall.
- Instruction counter:
  - Each edge: clear ? 0 : counter_inst + inst_valid.
  - Wraps at 2^32. Clear takes priority over a same-cycle retire; that retirement is not counted.
- FIFO push:
  - push = (btn_pulse != 0) & (~full | pop).
  - Stores all 3 bits as one entry, so simultaneous presses form a single entry.
  - Pulse while full with no pop: dropped silently, state unchanged.
- FIFO pop: pop = pop_req & ~empty. pop_req while empty has no effect and does not underflow.
- Show-ahead head: buttons is driven combinationally from storage[rd_ptr], so the load that pops reads the current head in the same cycle. rd_ptr advances at the following edge.
- Latency:
  - A pushed entry is visible on buttons and buttons_empty the cycle after the pulse.
  - A popped entry leaves the head the cycle after the pop.
- Simultaneous push and pop:
  - Not empty: both happen, count unchanged.
  - Full: the pop frees a slot, so the push is accepted.
  - Empty: only the push happens.
- Pointers wrap modulo FIFO_DEPTH. Count is PTR_W+1 bits. empty = (count==0), full = (count==FIFO_DEPTH).
- All outputs are combinational from registered state only; none depend combinationally on inputs.

Test Plan:
1. Reset then 10 free cycles with inst_valid high on 4 of them -> counter_cycle=10, counter_inst=4, buttons_empty=1, buttons=0.
2. Store to 0x8000_0018 with stall=0 while inst_valid=1 -> next cycle both counters are 0; the cycle after that, counter_cycle=1. Repeat with stall=1 -> no clear.
3. Preload counter_cycle to 0xFFFF_FFFE via forced state, run 2 cycles -> 0xFFFF_FFFF, then 0x0000_0000.
4. btn_pulse sequence 3'b001, 3'b110 -> buttons=3'b001. Load 0x8000_0024 -> that cycle reads 001, next cycle buttons=3'b110. Second pop -> buttons_empty=1, buttons=0. Third pop -> no change.
5. Push 9 pulses (values 1..7,1,2) with no pops -> buttons_full=1 and the 9th entry is dropped. Then pop and push 3'b101 in the same cycle -> full stays 1. After 8 more pops the output sequence is 2..7,1,5.
6. Push 3 entries, assert rst_n=0 in the same cycle as a pop and a pulse -> next cycle buttons_empty=1, both counters 0.

Source files
------------

// File: rtl/mmio_event_unit.sv
// MMIO status source: cycle counter, retired-instruction counter and a show-ahead button-event FIFO.
// Latency: counters and FIFO state update one edge after the event. Backpressure: a pulse is dropped when the FIFO is full with no pop.
module mmio_event_unit #(
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_W      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic        stall,
    input  logic        inst_valid,
    input  logic [2:0]  btn_pulse,
    output logic [31:0] counter_cycle,
    output logic [31:0] counter_inst,
    output logic        buttons_empty,
    output logic [2:0]  buttons,
    output logic        buttons_full
);

    localparam logic [31:0]    CLR_ADDR = 32'h8000_0018;
    localparam logic [31:0]    POP_ADDR = 32'h8000_0024;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [31:0]      r_cycle;
    logic [31:0]      r_inst;
    logic [2:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_clear;
    logic w_pop_req;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    // Stalled accesses are replayed later, so they must not trigger side effects now.
    assign w_clear   = mem_we & ~stall & (mem_addr == CLR_ADDR);
    assign w_pop_req = mem_re & ~stall & (mem_addr == POP_ADDR);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_FULL);
    assign w_pop   = w_pop_req & ~w_empty;
    assign w_push  = (btn_pulse != 3'b000) & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle <= '0;
            r_inst  <= '0;
        end else if (w_clear) begin
            r_cycle <= '0;
            r_inst  <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            r_inst  <= r_inst + {31'd0, inst_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr] <= btn_pulse;
        end
    end

    assign counter_cycle = r_cycle;
    assign counter_inst  = r_inst;
    assign buttons_empty = w_empty;
    assign buttons_full  = w_full;
    assign buttons       = w_empty ? 3'b000 : r_mem[r_rd_ptr];

endmodule

// File: tb/tb_mmio_event_unit.sv
// Directed self-checking bench for mmio_event_unit: counters, clear decode, wrap and button FIFO.
module tb_mmio_event_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic        stall;
    logic        inst_valid;
    logic [2:0]  btn_pulse;
    logic [31:0] counter_cycle;
    logic [31:0] counter_inst;
    logic        buttons_empty;
    logic [2:0]  buttons;
    logic        buttons_full;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] CLR_ADDR = 32'h8000_0018;
    localparam logic [31:0] POP_ADDR = 32'h8000_0024;

    mmio_event_unit #(.FIFO_DEPTH(8), .PTR_W(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_addr      (mem_addr),
        .mem_re        (mem_re),
        .mem_we        (mem_we),
        .stall         (stall),
        .inst_valid    (inst_valid),
        .btn_pulse     (btn_pulse),
        .counter_cycle (counter_cycle),
        .counter_inst  (counter_inst),
        .buttons_empty (buttons_empty),
        .buttons       (buttons),
        .buttons_full  (buttons_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mem_addr   = 32'd0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        stall      = 1'b0;
        inst_valid = 1'b0;
        btn_pulse  = 3'b000;
    endtask

    logic [2:0] fill_vals [9];
    logic [2:0] drain_vals [8];

    initial begin
        fill_vals  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};
        drain_vals = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd5};

        rst_n = 1'b0;
        idle_inputs();
        step();
        check("rst_cycle", counter_cycle, 32'd0);
        check("rst_inst", counter_inst, 32'd0);
        check("rst_empty", 32'(buttons_empty), 32'd1);
        check("rst_full", 32'(buttons_full), 32'd0);
        check("rst_buttons", 32'(buttons), 32'd0);

        // Ten free cycles, four retirements.
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            inst_valid = (i % 3 == 0) ? 1'b1 : 1'b0;
            step();
        end
        inst_valid = 1'b0;
        check("free_cycle", counter_cycle, 32'd10);
        check("free_inst", counter_inst, 32'd4);
        check("free_empty", 32'(buttons_empty), 32'd1);
        check("free_buttons", 32'(buttons), 32'd0);

        // Clear store beats a same-cycle retirement.
        mem_we = 1'b1; mem_addr = CLR_ADDR; inst_valid = 1'b1;
        step();
        idle_inputs();
        check("clr_cycle", counter_cycle, 32'd0);
        check("clr_inst", counter_inst, 32'd0);
        step();
        check("clr_cycle_next", counter_cycle, 32'd1);
        check("clr_inst_next", counter_inst, 32'd0);

        mem_we = 1'b1; mem_addr = CLR_ADDR; stall = 1'b1; inst_valid = 1'b1;
        step();
        idle_inputs();
        check("stall_clr_cycle", counter_cycle, 32'd2);
        check("stall_clr_inst", counter_inst, 32'd1);

        // A load to the clear address and a store to a near address do not clear.
        mem_re = 1'b1; mem_addr = CLR_ADDR;
        step();
        mem_re = 1'b0; mem_we = 1'b1; mem_addr = 32'h8000_0019;
        step();
        idle_inputs();
        check("noclr_cycle", counter_cycle, 32'd4);

        // Wrap of the cycle counter.
        force dut.r_cycle = 32'hFFFF_FFFE;
        #1;
        release dut.r_cycle;
        check("wrap_preload", counter_cycle, 32'hFFFF_FFFE);
        step();
        check("wrap_max", counter_cycle, 32'hFFFF_FFFF);
        step();
        check("wrap_zero", counter_cycle, 32'd0);

        // Show-ahead FIFO: push 001 then 110, pop three times.
        btn_pulse = 3'b001;
        step();
        check("push1_buttons", 32'(buttons), 32'd1);
        check("push1_empty", 32'(buttons_empty), 32'd0);
        btn_pulse = 3'b110;
        step();
        btn_pulse = 3'b000;
        check("push2_head", 32'(buttons), 32'd1);
        mem_re = 1'b1; mem_addr = POP_ADDR; stall = 1'b1;
        step();
        check("stalled_pop_head", 32'(buttons), 32'd1);
        stall = 1'b0;
        #1;
        check("pop1_same_cycle", 32'(buttons), 32'd1);
        step();
        check("pop1_next", 32'(buttons), 32'd6);
        step();
        check("pop2_empty", 32'(buttons_empty), 32'd1);
        check("pop2_buttons", 32'(buttons), 32'd0);
        step();
        check("pop3_empty", 32'(buttons_empty), 32'd1);
        check("pop3_buttons", 32'(buttons), 32'd0);
        check("pop3_full", 32'(buttons_full), 32'd0);
        idle_inputs();

        // Fill past capacity; the ninth pulse is dropped.
        for (int i = 0; i < 9; i++) begin
            btn_pulse = fill_vals[i];
            step();
            if (i == 6) check("almost_full", 32'(buttons_full), 32'd0);
        end
        btn_pulse = 3'b000;
        check("fill_full", 32'(buttons_full), 32'd1);
        check("fill_head", 32'(buttons), 32'd1);

        mem_re = 1'b1; mem_addr = POP_ADDR; btn_pulse = 3'b101;
        step();
        btn_pulse = 3'b000;
        check("poppush_full", 32'(buttons_full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d", i), 32'(buttons), 32'(drain_vals[i]));
            step();
        end
        idle_inputs();
        check("drain_empty", 32'(buttons_empty), 32'd1);
        check("drain_full", 32'(buttons_full), 32'd0);

        // Reset overrides a same-cycle pop, push and retirement.
        btn_pulse = 3'b011; step();
        btn_pulse = 3'b100; step();
        btn_pulse = 3'b111; step();
        btn_pulse = 3'b000;
        check("pre_rst_head", 32'(buttons), 32'd3);
        rst_n = 1'b0; mem_re = 1'b1; mem_addr = POP_ADDR; btn_pulse = 3'b001; inst_valid = 1'b1;
        step();
        idle_inputs();
        rst_n = 1'b1;
        check("rst2_empty", 32'(buttons_empty), 32'd1);
        check("rst2_buttons", 32'(buttons), 32'd0);
        check("rst2_cycle", counter_cycle, 32'd0);
        check("rst2_inst", counter_inst, 32'd0);
        step();
        check("rst2_cycle_next", counter_cycle, 32'd1);
        check("rst2_still_empty", 32'(buttons_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
